// File: rtl/rat_pkg.sv
// Shared definitions for the RAT MCU interrupt path: sequencer states,
// the interrupt vector and the pipeline depth that sets the drain length.
package rat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    INJECT = 2'd2,
    ACTIVE = 2'd3
  } intr_state_t;

  localparam logic [9:0] RAT_INTR_VECTOR = 10'h3FF;
  localparam int         RAT_PIPE_DEPTH  = 3;

endpackage

// File: rtl/rat_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// rising-edge detector on the synchronized value.
module rat_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic D,
  output logic RISE
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], D};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign RISE = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/rat_intr_sequencer.sv
// Interrupt sequencer: latches synchronized INTR edges, drains the pipeline
// while holding fetch, pulses the CU injection and blocks nesting until RETIE.
module rat_intr_sequencer
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = RAT_PIPE_DEPTH,
  parameter int CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             INTR,
  input  logic             I_EN,
  input  logic             BRN_IN_FLIGHT,
  input  logic             RETIE,
  output logic             FETCH_HOLD,
  output logic             INT_INJECT,
  output logic             INT_ACTIVE,
  output logic             INT_PEND,
  output logic [CNT_W-1:0] INT_COUNT
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  intr_state_t      state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             inject_q, inject_d;
  logic             active_q, active_d;
  logic             intr_rise_s;

  rat_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (INTR),
    .RISE    (intr_rise_s)
  );

  // A fresh edge on the injection cycle wins over the clear.
  always_comb begin
    pend_d = intr_rise_s | (pend_q & (state_q != INJECT));
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (pend_q && I_EN) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!I_EN) begin
          state_d = IDLE;
        end else if (BRN_IN_FLIGHT) begin
          drain_d = DRAIN_LOAD;
        end else if (drain_q == '0) begin
          state_d = INJECT;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      INJECT: state_d = ACTIVE;
      ACTIVE: begin
        if (RETIE) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    fetch_hold_d = (state_d == DRAIN) || (state_d == INJECT);
    inject_d     = (state_d == INJECT);
    active_d     = (state_d == ACTIVE);
    if (inject_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      fetch_hold_q <= 1'b0;
      inject_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      fetch_hold_q <= fetch_hold_d;
      inject_q     <= inject_d;
      active_q     <= active_d;
    end
  end

  assign FETCH_HOLD = fetch_hold_q;
  assign INT_INJECT = inject_q;
  assign INT_ACTIVE = active_q;
  assign INT_PEND   = pend_q;
  assign INT_COUNT  = count_q;

endmodule

// File: tb/tb_rat_intr_sequencer.sv
// Directed bench for rat_intr_sequencer; a second instance with a 2-bit
// counter shares the stimulus to observe counter saturation.
module tb_rat_intr_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       INTR;
  logic       I_EN;
  logic       BRN_IN_FLIGHT;
  logic       RETIE;
  logic       fh, inj, act, pend;
  logic [7:0] cnt;
  logic       fh2, inj2, act2, pend2;
  logic [1:0] cnt2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  rat_intr_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .INTR(INTR), .I_EN(I_EN),
    .BRN_IN_FLIGHT(BRN_IN_FLIGHT), .RETIE(RETIE),
    .FETCH_HOLD(fh), .INT_INJECT(inj), .INT_ACTIVE(act),
    .INT_PEND(pend), .INT_COUNT(cnt)
  );

  rat_intr_sequencer #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .INTR(INTR), .I_EN(I_EN),
    .BRN_IN_FLIGHT(BRN_IN_FLIGHT), .RETIE(RETIE),
    .FETCH_HOLD(fh2), .INT_INJECT(inj2), .INT_ACTIVE(act2),
    .INT_PEND(pend2), .INT_COUNT(cnt2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic retie_pulse();
    RETIE = 1'b1;
    step();
    RETIE = 1'b0;
    total_cnt++;
    if (act !== 1'b0 || fh !== 1'b0) $display("FAIL retie_idle act=%0b fh=%0b exp act=0 fh=0", act, fh);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; INTR = 1'b0; I_EN = 1'b1; BRN_IN_FLIGHT = 1'b0; RETIE = 1'b0;
    step(); step();
    total_cnt++;
    if ({fh, inj, act, pend, cnt} !== 12'h000) $display("FAIL reset_hold outs=%h exp=000", {fh, inj, act, pend, cnt});
    else pass_cnt++;
    RESET_N = 1'b1;
    step(); step();
    total_cnt++;
    if ({fh, inj, act, pend, cnt} !== 12'h000) $display("FAIL reset_release outs=%h exp=000", {fh, inj, act, pend, cnt});
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    INTR = 1'b1; step();                 // edge k
    INTR = 1'b0; step();                 // k+1
    total_cnt++;
    if (pend !== 1'b0) $display("FAIL nom_pend_k1 act=%0b exp=0", pend); else pass_cnt++;
    step();                              // k+2
    total_cnt++;
    if (pend !== 1'b1 || fh !== 1'b0) $display("FAIL nom_pend_k2 pend=%0b fh=%0b exp pend=1 fh=0", pend, fh);
    else pass_cnt++;
    step();                              // k+3
    total_cnt++;
    if (fh !== 1'b1) $display("FAIL nom_hold_k3 act=%0b exp=1", fh); else pass_cnt++;
    step(); step();                      // k+5
    total_cnt++;
    if (inj !== 1'b0) $display("FAIL nom_early_inj act=%0b exp=0", inj); else pass_cnt++;
    step();                              // k+6
    total_cnt++;
    if (inj !== 1'b1 || fh !== 1'b1 || act !== 1'b0 || cnt !== 8'd1)
      $display("FAIL nom_inject inj=%0b fh=%0b act=%0b cnt=%0d exp 1/1/0/1", inj, fh, act, cnt);
    else pass_cnt++;
    step();                              // k+7
    total_cnt++;
    if (inj !== 1'b0 || act !== 1'b1 || fh !== 1'b0 || pend !== 1'b0)
      $display("FAIL nom_active inj=%0b act=%0b fh=%0b pend=%0b exp 0/1/0/0", inj, act, fh, pend);
    else pass_cnt++;
    retie_pulse();
  endtask

  task automatic test_branch();
    INTR = 1'b1; step();                 // k
    INTR = 1'b0; step(); step(); step(); // k+3: draining
    BRN_IN_FLIGHT = 1'b1; step();        // k+4
    step();                              // k+5
    BRN_IN_FLIGHT = 1'b0;
    total_cnt++;
    if (fh !== 1'b1 || inj !== 1'b0) $display("FAIL brn_hold fh=%0b inj=%0b exp fh=1 inj=0", fh, inj);
    else pass_cnt++;
    step(); step();                      // k+7
    total_cnt++;
    if (inj !== 1'b0) $display("FAIL brn_restart inj=%0b exp=0", inj); else pass_cnt++;
    step();                              // k+8
    total_cnt++;
    if (inj !== 1'b1 || cnt !== 8'd2) $display("FAIL brn_inject inj=%0b cnt=%0d exp inj=1 cnt=2", inj, cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (inj !== 1'b0) $display("FAIL brn_single_pulse inj=%0b exp=0", inj); else pass_cnt++;
    retie_pulse();
  endtask

  task automatic test_ien();
    I_EN = 1'b0;
    INTR = 1'b1; step();
    INTR = 1'b0; step(); step(); step(); step(); // k+4
    total_cnt++;
    if (pend !== 1'b1 || fh !== 1'b0) $display("FAIL ien_blocked pend=%0b fh=%0b exp pend=1 fh=0", pend, fh);
    else pass_cnt++;
    I_EN = 1'b1; step();                 // DRAIN
    total_cnt++;
    if (fh !== 1'b1) $display("FAIL ien_drain fh=%0b exp=1", fh); else pass_cnt++;
    step(); step(); step();
    total_cnt++;
    if (inj !== 1'b1 || cnt !== 8'd3) $display("FAIL ien_inject inj=%0b cnt=%0d exp inj=1 cnt=3", inj, cnt);
    else pass_cnt++;
    step();
    retie_pulse();
    // I_EN falling mid-drain backs out and keeps the request
    INTR = 1'b1; step();
    INTR = 1'b0; step(); step(); step(); // k+3
    I_EN = 1'b0; step();                 // k+4
    total_cnt++;
    if (fh !== 1'b0 || pend !== 1'b1) $display("FAIL ien_abort fh=%0b pend=%0b exp fh=0 pend=1", fh, pend);
    else pass_cnt++;
    I_EN = 1'b1; step(); step(); step(); step();
    total_cnt++;
    if (inj !== 1'b1 || cnt !== 8'd4) $display("FAIL ien_resume inj=%0b cnt=%0d exp inj=1 cnt=4", inj, cnt);
    else pass_cnt++;
    step();
    retie_pulse();
  endtask

  task automatic test_active_nesting();
    INTR = 1'b1; step();
    INTR = 1'b0; step(); step(); step(); step(); step(); step(); // k+6 inject
    step();                              // k+7 active
    INTR = 1'b1; step();
    INTR = 1'b0; step(); step();
    total_cnt++;
    if (pend !== 1'b1 || act !== 1'b1 || inj !== 1'b0)
      $display("FAIL nest_latch pend=%0b act=%0b inj=%0b exp 1/1/0", pend, act, inj);
    else pass_cnt++;
    step(); step();
    total_cnt++;
    if (inj !== 1'b0 || fh !== 1'b0 || cnt !== 8'd5) $display("FAIL nest_blocked inj=%0b fh=%0b cnt=%0d exp 0/0/5", inj, fh, cnt);
    else pass_cnt++;
    RETIE = 1'b1; step();                // r
    RETIE = 1'b0;
    total_cnt++;
    if (act !== 1'b0 || fh !== 1'b0 || pend !== 1'b1) $display("FAIL nest_idle act=%0b fh=%0b pend=%0b exp 0/0/1", act, fh, pend);
    else pass_cnt++;
    step();                              // r+1
    total_cnt++;
    if (fh !== 1'b1) $display("FAIL nest_redrain fh=%0b exp=1", fh); else pass_cnt++;
    step(); step(); step();              // r+4
    total_cnt++;
    if (inj !== 1'b1 || cnt !== 8'd6) $display("FAIL nest_inject inj=%0b cnt=%0d exp inj=1 cnt=6", inj, cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pend !== 1'b0 || act !== 1'b1) $display("FAIL nest_clear pend=%0b act=%0b exp pend=0 act=1", pend, act);
    else pass_cnt++;
    retie_pulse();
  endtask

  task automatic test_held_level();
    INTR = 1'b1;
    repeat (7) step();                   // k+6
    total_cnt++;
    if (inj !== 1'b1 || cnt !== 8'd7) $display("FAIL held_inject inj=%0b cnt=%0d exp inj=1 cnt=7", inj, cnt);
    else pass_cnt++;
    step();
    retie_pulse();
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++;
      if (fh !== 1'b0 || pend !== 1'b0 || (fh & act) !== 1'b0)
        $display("FAIL held_no_retrigger cyc=%0d fh=%0b pend=%0b exp fh=0 pend=0", i, fh, pend);
      else pass_cnt++;
    end
    INTR = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_saturation();
    total_cnt++;
    if (cnt2 !== 2'd3) $display("FAIL sat_count act=%0d exp=3", cnt2); else pass_cnt++;
    total_cnt++;
    if (cnt !== 8'd7) $display("FAIL wide_count act=%0d exp=7", cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    INTR = 1'b1; step();
    INTR = 1'b0; step(); step(); step(); step(); // mid-drain
    total_cnt++;
    if (fh !== 1'b1) $display("FAIL rst_pre_drain fh=%0b exp=1", fh); else pass_cnt++;
    #2 RESET_N = 1'b0;
    #1;
    total_cnt++;
    if ({fh, inj, act, pend, cnt} !== 12'h000 || cnt2 !== 2'd0)
      $display("FAIL rst_async outs=%h cnt2=%0d exp outs=000 cnt2=0", {fh, inj, act, pend, cnt}, cnt2);
    else pass_cnt++;
    step();
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total_cnt++;
      if (inj !== 1'b0 || fh !== 1'b0) $display("FAIL rst_no_inject cyc=%0d inj=%0b fh=%0b exp 0/0", i, inj, fh);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_branch();
    test_ien();
    test_active_nesting();
    test_held_level();
    test_saturation();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
